des_round_ctrl: RTL and testbench

- Sequencing controller for the DES iterative core.
- Accepts one block per handshake and drives the left/right half-register controls for the initial load and the 16 round steps.
- Supplies per-round key-schedule control (round index, rotate amount, direction) and presents a done/valid handshake to the output stage.
- Sits between the block I/O wrapper and the L/R register, F-function and key-schedule datapath. It contains no data path itself.

---
 rtl/des_round_ctrl.sv | 138 +++++++++++++
 tb/tb_des_round_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// DES round sequencer: accepts a block, pulses the initial load,
// issues 16 round steps with key-schedule controls, then holds
// the result valid until the output stage takes it.
//
// Ports:
//   clk, rst (async, active-low), clear (sync abort)
//   in_valid/in_ready : block accept handshake, mode sampled on accept
//   load_init         : one-cycle L0/R0 and C0/D0 load pulse
//   round_en          : L/R step enable, 16 consecutive cycles
//   round_idx         : 0-based round number
//   key_shift         : C/D rotate amount for this round
//   key_dir           : 0 rotate left (encrypt), 1 rotate right
//   last_round        : final round marker
//   out_valid/out_ready : result handshake
//   busy              : controller not idle
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  output logic             load_init,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic [1:0]       key_shift,
  output logic             key_dir,
  output logic             last_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (clear) begin
      w_next    = S_IDLE;
      w_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_next    = S_LOAD;
            w_dir_nxt = mode;
          end
        end
        S_LOAD: begin
          w_cnt_nxt = '0;
          w_next    = S_ROUND;
        end
        S_ROUND: begin
          if (r_cnt == LAST) begin
            w_next    = S_DONE;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign load_init  = (r_state == S_LOAD);
  assign round_en   = (r_state == S_ROUND);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign key_dir    = r_dir;
  assign round_idx  = round_en ? r_cnt : '0;
  assign last_round = round_en && (r_cnt == LAST);

  // Single rotations fall on rounds 0,1,8,15. Decrypt skips the
  // rotation in round 0 since C16/D16 equals C0/D0.
  logic w_one_pos;
  logic w_zero;
  logic w_one;
  logic w_two;

  assign w_one_pos = (r_cnt == IDX_W'(0))
                  || (r_cnt == IDX_W'(1))
                  || (r_cnt == IDX_W'(8))
                  || (r_cnt == IDX_W'(15));
  assign w_zero = r_dir && (r_cnt == IDX_W'(0));
  assign w_one  = w_one_pos && !w_zero;
  assign w_two  = !w_one_pos;

  always_comb begin
    key_shift = 2'd0;
    if (round_en) begin
      unique case (1'b1)
        w_zero:  key_shift = 2'd0;
        w_one:   key_shift = 2'd1;
        w_two:   key_shift = 2'd2;
        default: key_shift = 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for the DES round sequencer.
// Inputs change 1ns after each rising edge; outputs checked then.
module tb_des_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic       load_init;
  logic       round_en;
  logic [3:0] round_idx;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       last_round;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] enc_sh [16];
  logic [1:0] dec_sh [16];

  des_round_ctrl #(.ROUNDS(16), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .load_init (load_init),
    .round_en  (round_en),
    .round_idx (round_idx),
    .key_shift (key_shift),
    .key_dir   (key_dir),
    .last_round(last_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] act;
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    #2;
    act = {in_ready, load_init, round_en, last_round, out_valid,
           busy, key_dir, key_shift, |round_idx};
    checks++;
    if (act !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset_outs act=%b exp=1000000000", act);
    end
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle in_ready=%b busy=%b exp=1/0",
               in_ready, busy);
    end
  endtask

  task automatic test_encrypt();
    mode      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (load_init !== 1'b1 || round_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enc_load li=%b re=%b bz=%b exp=1/0/1",
               load_init, round_en, busy);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (round_en !== 1'b1 || round_idx !== 4'(i)
          || key_shift !== enc_sh[i] || load_init !== 1'b0
          || last_round !== (i == 15)) begin
        errors++;
        $display("FAIL enc_round%0d re=%b idx=%0d ks=%0d lr=%b exp 1/%0d/%0d/%b",
                 i, round_en, round_idx, key_shift, last_round,
                 i, enc_sh[i], (i == 15));
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || round_en !== 1'b0 || in_ready !== 1'b0
        || key_shift !== 2'd0) begin
      errors++;
      $display("FAIL enc_done ov=%b re=%b ir=%b ks=%0d exp 1/0/0/0",
               out_valid, round_en, in_ready, key_shift);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enc_idle ir=%b ov=%b bz=%b exp 1/0/0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_decrypt();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (key_dir !== 1'b1 || load_init !== 1'b1) begin
      errors++;
      $display("FAIL dec_load kd=%b li=%b exp 1/1", key_dir, load_init);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 4) mode = 1'b0;
      checks++;
      if (round_en !== 1'b1 || round_idx !== 4'(i)
          || key_shift !== dec_sh[i] || key_dir !== 1'b1) begin
        errors++;
        $display("FAIL dec_round%0d re=%b idx=%0d ks=%0d kd=%b exp 1/%0d/%0d/1",
                 i, round_en, round_idx, key_shift, key_dir,
                 i, dec_sh[i]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || key_dir !== 1'b1) begin
      errors++;
      $display("FAIL dec_done ov=%b kd=%b exp 1/1", out_valid, key_dir);
    end
    step();
  endtask

  task automatic test_backpressure();
    int bad;
    mode      = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (load_init !== 1'b0 || round_en !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_rounds bad_cycles=%0d exp 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold bad_cycles=%0d exp 0", bad);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || load_init !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ir=%b ov=%b li=%b exp 1/0/0",
               in_ready, out_valid, load_init);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (load_init !== 1'b1) begin
      errors++;
      $display("FAIL bp_reaccept li=%b exp 1", load_init);
    end
    for (int i = 0; i < 18; i++) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain busy=%b exp 0", busy);
    end
  endtask

  task automatic test_abort();
    int rises;
    mode      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (round_idx !== 4'd7 || round_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pos idx=%0d re=%b exp 7/1", round_idx, round_en);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (round_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle re=%b bz=%b ir=%b exp 0/0/1",
               round_en, busy, in_ready);
    end
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid === 1'b1) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL abort_noout ov_cycles=%0d exp 0", rises);
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_init !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle bz=%b li=%b exp 0/0", busy, load_init);
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] act;
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) step();
    checks++;
    if (round_idx !== 4'd10 || key_dir !== 1'b1) begin
      errors++;
      $display("FAIL ar_pos idx=%0d kd=%b exp 10/1", round_idx, key_dir);
    end
    #2;
    rst = 1'b0;
    #1;
    act = {in_ready, load_init, round_en, last_round, out_valid,
           busy, key_dir, key_shift, |round_idx};
    checks++;
    if (act !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL ar_outs act=%b exp=1000000000", act);
    end
    step();
    rst  = 1'b1;
    mode = 1'b0;
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (load_init !== 1'b1) begin
      errors++;
      $display("FAIL ar_load li=%b exp 1", load_init);
    end
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (last_round !== 1'b1 || round_idx !== 4'd15) begin
      errors++;
      $display("FAIL ar_last lr=%b idx=%0d exp 1/15", last_round, round_idx);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_done ov=%b exp 1", out_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int loads;
    int rnds;
    int lc [3];
    loads = 0;
    rnds  = 0;
    lc    = '{0, 0, 0};
    mode      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    for (int c = 1; c <= 56; c++) begin
      if (load_init === 1'b1) begin
        if (loads < 3) lc[loads] = c;
        loads++;
      end
      if (round_en === 1'b1) rnds++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (loads != 3 || rnds != 48) begin
      errors++;
      $display("FAIL b2b_counts loads=%0d rounds=%0d exp 3/48", loads, rnds);
    end
    checks++;
    if (lc[0] != 1 || lc[1] - lc[0] != 19 || lc[2] - lc[1] != 19) begin
      errors++;
      $display("FAIL b2b_spacing at %0d,%0d,%0d exp 1,20,39",
               lc[0], lc[1], lc[2]);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle ir=%b exp 1", in_ready);
    end
    step();
    checks++;
    if (busy !== 1'b0 || load_init !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop bz=%b li=%b exp 0/0", busy, load_init);
    end
  endtask

  initial begin
    enc_sh = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    dec_sh = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
